// File: rtl/kdb_pkg.sv
//------------------------------------------------------------------------------
// Module   : kdb_pkg
// Brief    : Shared types and helpers for the key debounce block.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package kdb_pkg;

  localparam int DEBOUNCE_CYCLES_100M = 2000000;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } kdb_state_t;

  // Counter covers 0..cycles-1; kept at least one bit wide.
  function automatic int kdb_cnt_w(input int cycles);
    return (cycles <= 2) ? 1 : $clog2(cycles);
  endfunction

endpackage

`default_nettype wire

// File: rtl/key_debounce_chan.sv
//------------------------------------------------------------------------------
// Module   : key_debounce_chan
// Brief    : One key: 2-flop synchroniser, debounce FSM and registered pulses.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module key_debounce_chan
  import kdb_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_100M,
  parameter bit KEY_ACTIVE_LOW  = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_key_raw,
  output logic o_press,
  output logic o_release,
  output logic o_level
);

  localparam int               c_cnt_w    = kdb_cnt_w(DEBOUNCE_CYCLES);
  localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(DEBOUNCE_CYCLES - 1);
  localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);

  logic               r_sync1;
  logic               r_sync2;
  kdb_state_t         r_state;
  logic [c_cnt_w-1:0] r_cnt;
  logic               r_press;
  logic               r_release;
  logic               r_level;
  logic               w_act;

  assign w_act = r_sync2 ^ KEY_ACTIVE_LOW;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      // Synchroniser parks at the idle raw level so reset exit never looks like a press.
      r_sync1   <= KEY_ACTIVE_LOW;
      r_sync2   <= KEY_ACTIVE_LOW;
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_press   <= 1'b0;
      r_release <= 1'b0;
      r_level   <= 1'b0;
    end else begin
      r_sync1   <= i_key_raw;
      r_sync2   <= r_sync1;
      r_press   <= 1'b0;
      r_release <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_act) begin
            r_state <= PRESS_WAIT;
            r_cnt   <= '0;
          end
        end
        PRESS_WAIT: begin
          if (!w_act) begin
            r_state <= IDLE;
            r_cnt   <= '0;
          end else if (r_cnt == c_cnt_last) begin
            r_state <= PRESSED;
            r_cnt   <= '0;
            r_press <= 1'b1;
            r_level <= 1'b1;
          end else begin
            r_cnt <= r_cnt + c_cnt_one;
          end
        end
        PRESSED: begin
          if (!w_act) begin
            r_state <= RELEASE_WAIT;
            r_cnt   <= '0;
          end
        end
        RELEASE_WAIT: begin
          // A bounce back to active returns silently: the press was already reported.
          if (w_act) begin
            r_state <= PRESSED;
            r_cnt   <= '0;
          end else if (r_cnt == c_cnt_last) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_release <= 1'b1;
            r_level   <= 1'b0;
          end else begin
            r_cnt <= r_cnt + c_cnt_one;
          end
        end
        default: begin
          r_state <= IDLE;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  assign o_press   = r_press;
  assign o_release = r_release;
  assign o_level   = r_level;

endmodule

`default_nettype wire

// File: rtl/key_debounce_pulse.sv
//------------------------------------------------------------------------------
// Module   : key_debounce_pulse
// Brief    : Independent debounce channels for the board push-buttons.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module key_debounce_pulse
  import kdb_pkg::*;
#(
  parameter int NUM_KEYS        = 2,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_100M,
  parameter bit KEY_ACTIVE_LOW  = 1'b1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NUM_KEYS-1:0] key_raw,
  output logic [NUM_KEYS-1:0] key_press,
  output logic [NUM_KEYS-1:0] key_release,
  output logic [NUM_KEYS-1:0] key_level
);

  generate
    for (genvar k = 0; k < NUM_KEYS; k++) begin : g_chan
      key_debounce_chan #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .KEY_ACTIVE_LOW  (KEY_ACTIVE_LOW)
      ) u_chan (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_key_raw (key_raw[k]),
        .o_press   (key_press[k]),
        .o_release (key_release[k]),
        .o_level   (key_level[k])
      );
    end
  endgenerate

endmodule

`default_nettype wire
